sobel_window_ctrl: RTL

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

---
 rtl/sobel_window_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for a 3x3 Sobel window: counts pixels of one frame,
// drives line-buffer writes and window shifts, and flags complete windows.
module sobel_window_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             pix_valid_i,
    output logic             lb_wr_en_o,
    output logic [CNT_W-1:0] lb_addr_o,
    output logic             win_shift_o,
    output logic             win_valid_o,
    output logic [CNT_W-1:0] col_o,
    output logic [CNT_W-1:0] row_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overrun_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_e;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             overrun_q, overrun_d;
    logic             accept, win_hit;

    logic             lb_wr_en_q, win_shift_q, win_valid_q;
    logic             busy_q, frame_done_q;
    logic [CNT_W-1:0] lb_addr_q, col_o_q, row_o_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        overrun_d = overrun_q;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pix_valid_i) overrun_d = 1'b1;
                // A simultaneous start overrides the overrun raised by a stray pixel.
                if (start_i) begin
                    state_d   = S_FILL;
                    col_d     = '0;
                    row_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            S_FILL, S_RUN: begin
                if (pix_valid_i) begin
                    accept = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                        if (state_q == S_FILL && row_q == CNT_W'(1)) state_d = S_RUN;
                        if (state_q == S_RUN && row_q == ROW_LAST)   state_d = S_DONE;
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (pix_valid_i) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign win_hit = accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            overrun_q    <= 1'b0;
            lb_wr_en_q   <= 1'b0;
            win_shift_q  <= 1'b0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            lb_addr_q    <= '0;
            col_o_q      <= '0;
            row_o_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            overrun_q    <= overrun_d;
            lb_wr_en_q   <= accept;
            win_shift_q  <= accept;
            win_valid_q  <= win_hit;
            busy_q       <= (state_d == S_FILL) || (state_d == S_RUN);
            frame_done_q <= (state_q == S_DONE);
            if (accept) lb_addr_q <= col_q;
            if (win_hit) begin
                col_o_q <= col_q - CNT_W'(1);
                row_o_q <= row_q - CNT_W'(1);
            end
        end
    end

    assign lb_wr_en_o    = lb_wr_en_q;
    assign lb_addr_o     = lb_addr_q;
    assign win_shift_o   = win_shift_q;
    assign win_valid_o   = win_valid_q;
    assign col_o         = col_o_q;
    assign row_o         = row_o_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign overrun_err_o = overrun_q;

endmodule
